ll_fifo_reserved: RTL and testbench

- Next-generation shared-storage linked-list FIFO. NUM_FIFOS logical queues share one DEPTH-entry data memory, linked through per-entry next pointers, with a free list.
- Adds a per-queue minimum reservation (RESERVE entries), so one queue cannot starve the others.
- Adds per-queue full flags, per-queue occupancy counts, and a registered read port with a valid strobe.
- Illegal push/pop is rejected in hardware (accept strobes), not left to environment constraints.
- Sits between ingress arbitration and per-channel consumers.

---
 rtl/ll_fifo_pkg.sv | 24 ++
 rtl/ll_free_list.sv | 91 +++++++++
 rtl/ll_fifo_reserved.sv | 207 ++++++++++++++++++++
 tb/tb_ll_fifo_reserved.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ll_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ll_fifo_pkg
//   Shared helpers for the reserved linked-list FIFO.
//   - unused_res     : reservation a queue still holds but has not filled.
//   - free_init_next : next-pointer value of an entry in the reset free chain
//                      (0 -> 1 -> ... -> DEPTH-1).
//   The per-queue state record depends on the instance parameters, so it is
//   declared inside the top module (q_state_t) from the same fields:
//   head, tail, count.
// ---------------------------------------------------------------------------
package ll_fifo_pkg;

    // Entries still owed to a queue: max(reserve - cnt, 0).
    function automatic int unused_res(input int reserve, input int cnt);
        return (cnt < reserve) ? (reserve - cnt) : 0;
    endfunction

    // Reset free chain links each entry to its successor; the last entry's
    // link is never followed while it is the free tail, so 0 is used.
    function automatic int free_init_next(input int idx, input int depth);
        return (idx + 1 < depth) ? (idx + 1) : 0;
    endfunction

endpackage

// File: rtl/ll_free_list.sv
// ---------------------------------------------------------------------------
// ll_free_list
//   Owns the free chain: free head, free tail and free count. The next-pointer
//   storage lives in the top level; this block tells the top when to link the
//   released entry behind the current free tail.
//
//   Ports
//     clk, rst            clock, asynchronous active-low reset
//     i_alloc             take the entry at o_alloc_ptr this cycle
//     i_release           return i_release_ptr to the free list this cycle
//     i_release_ptr       entry being returned
//     i_next_of_head      next[free_head], read by the top from its storage
//     o_alloc_ptr         current free head (entry a push will use)
//     o_free_count        entries on the free list
//     o_link_we           write next[o_link_ptr] <= i_release_ptr
//     o_link_ptr          current free tail
// ---------------------------------------------------------------------------
module ll_free_list #(
    parameter int DEPTH     = 8,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_alloc,
    input  logic                 i_release,
    input  logic [PTR_WIDTH-1:0] i_release_ptr,
    input  logic [PTR_WIDTH-1:0] i_next_of_head,
    output logic [PTR_WIDTH-1:0] o_alloc_ptr,
    output logic [CNT_WIDTH-1:0] o_free_count,
    output logic                 o_link_we,
    output logic [PTR_WIDTH-1:0] o_link_ptr
);

    logic [PTR_WIDTH-1:0] r_head;
    logic [PTR_WIDTH-1:0] r_tail;
    logic [CNT_WIDTH-1:0] r_count;

    logic w_empty;
    logic w_last;

    assign w_empty      = (r_count == '0);
    assign w_last       = (r_count == CNT_WIDTH'(1));
    assign o_alloc_ptr  = r_head;
    assign o_free_count = r_count;
    assign o_link_ptr   = r_tail;

    // A release is chained behind the tail unless the list is (or is about
    // to become) empty, in which case the released entry becomes the whole
    // list on its own and no link is needed.
    always_comb begin
        o_link_we = 1'b0;
        if (i_release && !w_empty && !(i_alloc && w_last)) begin
            o_link_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= PTR_WIDTH'(DEPTH - 1);
            r_count <= CNT_WIDTH'(DEPTH);
        end else begin
            case ({i_alloc, i_release})
                2'b10: begin
                    r_head  <= i_next_of_head;
                    r_count <= r_count - CNT_WIDTH'(1);
                end
                2'b01: begin
                    if (w_empty) begin
                        r_head <= i_release_ptr;
                    end
                    r_tail  <= i_release_ptr;
                    r_count <= r_count + CNT_WIDTH'(1);
                end
                2'b11: begin
                    // The alloc always uses the pre-cycle head; when that was
                    // the last free entry the released one replaces it.
                    if (w_last) begin
                        r_head <= i_release_ptr;
                    end else begin
                        r_head <= i_next_of_head;
                    end
                    r_tail <= i_release_ptr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ll_fifo_reserved.sv
// ---------------------------------------------------------------------------
// ll_fifo_reserved
//   NUM_FIFOS logical FIFOs sharing one DEPTH-entry memory through per-entry
//   next pointers and a free list. Each queue is guaranteed RESERVE entries:
//   a push is refused when the free entries left would not cover the unused
//   reservations of the other queues.
//
//   Handshake: push/pop are requests; push_ok/pop_ok are combinational
//   accepts from current state. Only accepted requests change state. A popped
//   word appears on data_out one cycle later with data_out_vld high for that
//   single cycle; data_out otherwise holds.
//
//   Ports
//     clk, rst                  clock, asynchronous active-low reset
//     push, push_sel, data_in   push request, target queue, data
//     push_ok                   push accepted this cycle
//     pop, pop_sel              pop request, source queue
//     pop_ok                    pop accepted this cycle
//     data_out, data_out_vld    registered popped word and its strobe
//     empty, full               per-queue flags
//     count                     per-queue occupancy, queue i at
//                               [i*CNT_WIDTH +: CNT_WIDTH]
//     free_count                entries on the free list
// ---------------------------------------------------------------------------
module ll_fifo_reserved
    import ll_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int NUM_FIFOS = 4,
    parameter int RESERVE   = 1,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int SEL_WIDTH = $clog2(NUM_FIFOS),
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [SEL_WIDTH-1:0]           push_sel,
    input  logic [WIDTH-1:0]               data_in,
    output logic                           push_ok,
    input  logic                           pop,
    input  logic [SEL_WIDTH-1:0]           pop_sel,
    output logic                           pop_ok,
    output logic [WIDTH-1:0]               data_out,
    output logic                           data_out_vld,
    output logic [NUM_FIFOS-1:0]           empty,
    output logic [NUM_FIFOS-1:0]           full,
    output logic [NUM_FIFOS*CNT_WIDTH-1:0] count,
    output logic [CNT_WIDTH-1:0]           free_count
);

    typedef struct packed {
        logic [PTR_WIDTH-1:0] head;
        logic [PTR_WIDTH-1:0] tail;
        logic [CNT_WIDTH-1:0] count;
    } q_state_t;

    q_state_t             r_q    [NUM_FIFOS];
    logic [PTR_WIDTH-1:0] r_next [DEPTH];
    logic [WIDTH-1:0]     r_mem  [DEPTH];
    logic [WIDTH-1:0]     r_data_out;
    logic                 r_data_out_vld;

    logic [PTR_WIDTH-1:0] w_alloc_ptr;
    logic [CNT_WIDTH-1:0] w_free_count;
    logic                 w_free_link_we;
    logic [PTR_WIDTH-1:0] w_free_link_ptr;

    int                   w_unused [NUM_FIFOS];
    int                   w_unused_total;
    int                   w_avail  [NUM_FIFOS];
    logic                 w_push_ok;
    logic                 w_pop_ok;
    logic [PTR_WIDTH-1:0] w_pop_head;
    logic [PTR_WIDTH-1:0] w_push_tail;
    logic                 w_push_link;
    logic                 w_same_single;
    logic [NUM_FIFOS-1:0] w_push_hit;
    logic [NUM_FIFOS-1:0] w_pop_hit;

    // Flags from current state only; a same-cycle pop never frees room for
    // a same-cycle push.
    always_comb begin
        w_unused_total = 0;
        empty          = '0;
        full           = '0;
        count          = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            w_unused[i]    = unused_res(RESERVE, int'(r_q[i].count));
            w_unused_total = w_unused_total + w_unused[i];
        end
        for (int i = 0; i < NUM_FIFOS; i++) begin
            w_avail[i] = int'(w_free_count) - (w_unused_total - w_unused[i]);
            empty[i]   = (r_q[i].count == '0);
            full[i]    = (w_avail[i] <= 0);
            count[i*CNT_WIDTH +: CNT_WIDTH] = r_q[i].count;
        end
    end

    assign w_push_ok = push & ~full[push_sel];
    assign w_pop_ok  = pop & ~empty[pop_sel];
    assign push_ok   = w_push_ok;
    assign pop_ok    = w_pop_ok;

    assign w_pop_head  = r_q[pop_sel].head;
    assign w_push_tail = r_q[push_sel].tail;
    assign w_push_link = w_push_ok && (r_q[push_sel].count != '0);

    // Push and pop on a one-entry queue: the old entry leaves and the pushed
    // entry becomes both head and tail (its link is not written yet).
    assign w_same_single = w_push_ok && w_pop_ok && (push_sel == pop_sel) &&
                           (r_q[pop_sel].count == CNT_WIDTH'(1));

    always_comb begin
        w_push_hit = '0;
        w_pop_hit  = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            w_push_hit[i] = w_push_ok && (push_sel == SEL_WIDTH'(i));
            w_pop_hit[i]  = w_pop_ok && (pop_sel == SEL_WIDTH'(i));
        end
    end

    ll_free_list #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_free_list (
        .clk            (clk),
        .rst            (rst),
        .i_alloc        (w_push_ok),
        .i_release      (w_pop_ok),
        .i_release_ptr  (w_pop_head),
        .i_next_of_head (r_next[w_alloc_ptr]),
        .o_alloc_ptr    (w_alloc_ptr),
        .o_free_count   (w_free_count),
        .o_link_we      (w_free_link_we),
        .o_link_ptr     (w_free_link_ptr)
    );

    assign free_count = w_free_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                if (w_push_hit[i]) begin
                    r_q[i].tail <= w_alloc_ptr;
                    if (r_q[i].count == '0) begin
                        r_q[i].head <= w_alloc_ptr;
                    end
                end
                if (w_pop_hit[i]) begin
                    r_q[i].head <= w_same_single ? w_alloc_ptr : r_next[r_q[i].head];
                end
                case ({w_push_hit[i], w_pop_hit[i]})
                    2'b10:   r_q[i].count <= r_q[i].count + CNT_WIDTH'(1);
                    2'b01:   r_q[i].count <= r_q[i].count - CNT_WIDTH'(1);
                    default: ;
                endcase
            end
        end
    end

    // Two link writes per cycle: the push extends its queue, the free list
    // extends the free chain. They address a queue tail and the free tail,
    // which are never the same entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_next[i] <= PTR_WIDTH'(free_init_next(i, DEPTH));
            end
        end else begin
            if (w_push_link) begin
                r_next[w_push_tail] <= w_alloc_ptr;
            end
            if (w_free_link_we) begin
                r_next[w_free_link_ptr] <= w_pop_head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_alloc_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out     <= '0;
            r_data_out_vld <= 1'b0;
        end else begin
            r_data_out_vld <= w_pop_ok;
            if (w_pop_ok) begin
                r_data_out <= r_mem[w_pop_head];
            end
        end
    end

    assign data_out     = r_data_out;
    assign data_out_vld = r_data_out_vld;

endmodule

// File: tb/tb_ll_fifo_reserved.sv
module tb_ll_fifo_reserved;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int NQ = 2;
  localparam int R  = 1;
  localparam int CW = $clog2(D + 1);
  localparam int SW = $clog2(NQ);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              push = 1'b0;
  logic [SW-1:0]     push_sel = '0;
  logic [W-1:0]      data_in = '0;
  logic              push_ok;
  logic              pop = 1'b0;
  logic [SW-1:0]     pop_sel = '0;
  logic              pop_ok;
  logic [W-1:0]      data_out;
  logic              data_out_vld;
  logic [NQ-1:0]     empty;
  logic [NQ-1:0]     full;
  logic [NQ*CW-1:0]  count;
  logic [CW-1:0]     free_count;

  int errors = 0;
  int checks = 0;

  // scoreboard: one expected queue per logical FIFO
  logic [W-1:0] exp_q[NQ][$];

  ll_fifo_reserved #(
    .WIDTH(W), .DEPTH(D), .NUM_FIFOS(NQ), .RESERVE(R)
  ) dut (
    .clk(clk), .rst(rst),
    .push(push), .push_sel(push_sel), .data_in(data_in), .push_ok(push_ok),
    .pop(pop), .pop_sel(pop_sel), .pop_ok(pop_ok),
    .data_out(data_out), .data_out_vld(data_out_vld),
    .empty(empty), .full(full), .count(count), .free_count(free_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] cnt_of(input int q);
    return count[q*CW +: CW];
  endfunction

  // driver tasks
  task automatic drive(input logic p, input int ps, input logic [W-1:0] d,
                       input logic o, input int os);
    push     = p;
    push_sel = SW'(ps);
    data_in  = d;
    pop      = o;
    pop_sel  = SW'(os);
  endtask

  task automatic idle();
    drive(1'b0, 0, '0, 1'b0, 0);
  endtask

  // advance one clock; inputs return to idle at the falling edge
  task automatic next_cycle();
    @(negedge clk);
    idle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (empty !== 2'b11) begin errors++; $display("FAIL reset_empty: got %b expected 11", empty); end
    checks++; if (full !== 2'b00) begin errors++; $display("FAIL reset_full: got %b expected 00", full); end
    checks++; if (free_count !== CW'(D)) begin errors++; $display("FAIL reset_free_count: got %0d expected %0d", free_count, D); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %h expected 0", count); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    checks++; if (data_out_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", data_out_vld); end
  endtask

  task automatic test_push_fill();
    logic [W-1:0] d;
    for (int i = 0; i < 3; i++) begin
      d = 8'hA1 + W'(i);
      drive(1'b1, 0, d, 1'b0, 0);
      #1;
      checks++; if (push_ok !== 1'b1) begin errors++; $display("FAIL fill_push_ok[%0d]: got %b expected 1", i, push_ok); end
      exp_q[0].push_back(d);
      next_cycle();
    end
    checks++; if (cnt_of(0) !== CW'(3)) begin errors++; $display("FAIL fill_count0: got %0d expected 3", cnt_of(0)); end
    checks++; if (full !== 2'b01) begin errors++; $display("FAIL fill_full: got %b expected 01", full); end
    checks++; if (free_count !== CW'(1)) begin errors++; $display("FAIL fill_free: got %0d expected 1", free_count); end
    // q0 may not eat q1's reserved entry
    drive(1'b1, 0, 8'hA4, 1'b0, 0);
    #1;
    checks++; if (push_ok !== 1'b0) begin errors++; $display("FAIL reserve_reject: got %b expected 0", push_ok); end
    next_cycle();
    checks++; if (cnt_of(0) !== CW'(3)) begin errors++; $display("FAIL reserve_count0: got %0d expected 3", cnt_of(0)); end
    checks++; if (free_count !== CW'(1)) begin errors++; $display("FAIL reserve_free: got %0d expected 1", free_count); end
    drive(1'b1, 1, 8'hB1, 1'b0, 0);
    #1;
    checks++; if (push_ok !== 1'b1) begin errors++; $display("FAIL q1_push_ok: got %b expected 1", push_ok); end
    exp_q[1].push_back(8'hB1);
    next_cycle();
    checks++; if (full !== 2'b11) begin errors++; $display("FAIL pool_full: got %b expected 11", full); end
    checks++; if (free_count !== '0) begin errors++; $display("FAIL pool_free: got %0d expected 0", free_count); end
  endtask

  task automatic test_pop_order();
    logic [W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, '0, 1'b1, 0);
      #1;
      checks++; if (pop_ok !== 1'b1) begin errors++; $display("FAIL pop_ok[%0d]: got %b expected 1", i, pop_ok); end
      e = exp_q[0].pop_front();
      next_cycle();
      checks++; if (data_out_vld !== 1'b1) begin errors++; $display("FAIL pop_vld[%0d]: got %b expected 1", i, data_out_vld); end
      checks++; if (data_out !== e) begin errors++; $display("FAIL pop_data[%0d]: got %h expected %h", i, data_out, e); end
    end
    drive(1'b0, 0, '0, 1'b1, 0);
    #1;
    checks++; if (pop_ok !== 1'b0) begin errors++; $display("FAIL pop_empty_ok: got %b expected 0", pop_ok); end
    next_cycle();
    checks++; if (data_out_vld !== 1'b0) begin errors++; $display("FAIL pop_empty_vld: got %b expected 0", data_out_vld); end
    checks++; if (data_out !== e) begin errors++; $display("FAIL pop_hold: got %h expected %h", data_out, e); end
  endtask

  task automatic test_same_queue();
    logic [W-1:0] e;
    drive(1'b1, 1, 8'hB2, 1'b1, 1);
    #1;
    checks++; if (push_ok !== 1'b1 || pop_ok !== 1'b1) begin errors++; $display("FAIL same_q_ok: got %b%b expected 11", push_ok, pop_ok); end
    e = exp_q[1].pop_front();
    exp_q[1].push_back(8'hB2);
    next_cycle();
    checks++; if (data_out !== e || data_out_vld !== 1'b1) begin errors++; $display("FAIL same_q_data: got %h/%b expected %h/1", data_out, data_out_vld, e); end
    checks++; if (cnt_of(1) !== CW'(1)) begin errors++; $display("FAIL same_q_count1: got %0d expected 1", cnt_of(1)); end
    drive(1'b0, 0, '0, 1'b1, 1);
    #1;
    e = exp_q[1].pop_front();
    next_cycle();
    checks++; if (data_out !== e) begin errors++; $display("FAIL same_q_second: got %h expected %h", data_out, e); end
    checks++; if (empty[1] !== 1'b1) begin errors++; $display("FAIL same_q_empty: got %b expected 1", empty[1]); end
  endtask

  task automatic test_full_pool();
    logic [W-1:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 3) ? 1 : 0, 8'hC1 + W'(i), 1'b0, 0);
      #1;
      checks++; if (push_ok !== 1'b1) begin errors++; $display("FAIL pool_fill_ok[%0d]: got %b expected 1", i, push_ok); end
      exp_q[(i == 3) ? 1 : 0].push_back(8'hC1 + W'(i));
      next_cycle();
    end
    drive(1'b1, 1, 8'hD2, 1'b1, 0);
    #1;
    checks++; if (push_ok !== 1'b0) begin errors++; $display("FAIL no_credit_push: got %b expected 0", push_ok); end
    checks++; if (pop_ok !== 1'b1) begin errors++; $display("FAIL no_credit_pop: got %b expected 1", pop_ok); end
    e = exp_q[0].pop_front();
    next_cycle();
    checks++; if (free_count !== CW'(1)) begin errors++; $display("FAIL no_credit_free: got %0d expected 1", free_count); end
    checks++; if (data_out !== e) begin errors++; $display("FAIL no_credit_data: got %h expected %h", data_out, e); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1, 8'hF1, 1'b1, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (empty !== 2'b11) begin errors++; $display("FAIL arst_empty: got %b expected 11", empty); end
    checks++; if (free_count !== CW'(D)) begin errors++; $display("FAIL arst_free: got %0d expected %0d", free_count, D); end
    checks++; if (count !== '0) begin errors++; $display("FAIL arst_count: got %h expected 0", count); end
    checks++; if (data_out_vld !== 1'b0 || data_out !== '0) begin errors++; $display("FAIL arst_data: got %h/%b expected 0/0", data_out, data_out_vld); end
    checks++; if (full !== 2'b00) begin errors++; $display("FAIL arst_full: got %b expected 00", full); end
    for (int q = 0; q < NQ; q++) exp_q[q].delete();
    @(negedge clk);
    idle();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_random();
    int sz[NQ];
    int fr, un0, un1, ps, os, sum;
    logic p, o, exp_push_ok, exp_pop_ok, pend_v;
    logic [W-1:0] d, pend;
    for (int n = 0; n < 2000; n++) begin
      for (int q = 0; q < NQ; q++) sz[q] = exp_q[q].size();
      fr  = D - sz[0] - sz[1];
      un0 = (sz[0] < R) ? R - sz[0] : 0;
      un1 = (sz[1] < R) ? R - sz[1] : 0;
      p   = ($urandom_range(0, 99) < 60);
      o   = ($urandom_range(0, 99) < 50);
      ps  = $urandom_range(0, NQ - 1);
      os  = $urandom_range(0, NQ - 1);
      d   = W'($urandom_range(0, 255));
      exp_push_ok = p && (((ps == 0) ? (fr - un1) : (fr - un0)) > 0);
      exp_pop_ok  = o && (sz[os] > 0);
      drive(p, ps, d, o, os);
      #1;
      checks++; if (push_ok !== exp_push_ok) begin errors++; $display("FAIL rnd_push_ok[%0d]: got %b expected %b", n, push_ok, exp_push_ok); end
      checks++; if (pop_ok !== exp_pop_ok) begin errors++; $display("FAIL rnd_pop_ok[%0d]: got %b expected %b", n, pop_ok, exp_pop_ok); end
      pend_v = exp_pop_ok;
      pend   = '0;
      if (exp_pop_ok) pend = exp_q[os].pop_front();
      if (exp_push_ok) exp_q[ps].push_back(d);
      next_cycle();
      checks++; if (data_out_vld !== pend_v) begin errors++; $display("FAIL rnd_vld[%0d]: got %b expected %b", n, data_out_vld, pend_v); end
      if (pend_v) begin
        checks++; if (data_out !== pend) begin errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", n, data_out, pend); end
      end
      for (int q = 0; q < NQ; q++) begin
        checks++; if (cnt_of(q) !== CW'(exp_q[q].size())) begin errors++; $display("FAIL rnd_count%0d[%0d]: got %0d expected %0d", q, n, cnt_of(q), exp_q[q].size()); end
      end
      sum = int'(cnt_of(0)) + int'(cnt_of(1)) + int'(free_count);
      checks++; if (sum != D) begin errors++; $display("FAIL rnd_conserve[%0d]: got %0d expected %0d", n, sum, D); end
    end
  endtask

  initial begin
    test_reset();
    test_push_fill();
    test_pop_order();
    test_same_queue();
    test_full_pool();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
